// File: rtl/ctr_game_pkg.sv
// rtl/ctr_game_pkg.sv - shared types and constants for the counter-game driver
package ctr_game_pkg;

  localparam int COUNTER_SIZE = 4;
  typedef logic [COUNTER_SIZE-1:0] counter_t;
  localparam counter_t COUNTER_MAX = '1;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } control_t;

  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'b00,
    MODE_ALT    = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_AIM    = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PLAY   = 3'd2,
    RESYNC = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Counter step for one control code; wraps modulo 2^COUNTER_SIZE.
  function automatic counter_t apply_control(input counter_t value, input control_t code);
    case (code)
      UP1:     return value + counter_t'(1);
      UP2:     return value + counter_t'(2);
      DN1:     return value - counter_t'(1);
      default: return value - counter_t'(2);
    endcase
  endfunction

endpackage

// File: rtl/ctr_game_driver_if.sv
// rtl/ctr_game_driver_if.sv - driver <-> counter-game signal bundle
interface ctr_game_if;
  import ctr_game_pkg::*;

  control_t   control;
  logic       init;
  counter_t   initial_value;
  logic       winner;
  logic       loser;
  logic       gameover;
  logic [1:0] who;

  modport master (
    output control, init, initial_value,
    input  winner, loser, gameover, who
  );

  modport slave (
    input  control, init, initial_value,
    output winner, loser, gameover, who
  );

endinterface

// File: rtl/ctr_game_strategy.sv
// rtl/ctr_game_strategy.sv - next control code per strategy, plus LFSR and alternate toggle
module ctr_game_strategy
  import ctr_game_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     advance,
  input  mode_t    mode,
  input  control_t fixed_control,
  input  logic     goal_win,
  input  counter_t shadow,
  output control_t next_control
);

  logic [7:0] lfsr;
  logic       toggle;
  logic       feedback;

  // Fibonacci taps 8,6,5,4
  assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr   <= LFSR_SEED;
      toggle <= 1'b0;
    end else if (advance) begin
      lfsr   <= {lfsr[6:0], feedback};
      toggle <= ~toggle;
    end
  end

  always_comb begin
    next_control = UP1;
    case (mode)
      MODE_FIXED:  next_control = fixed_control;
      MODE_ALT:    next_control = toggle ? DN2 : UP2;
      MODE_RANDOM: next_control = control_t'(lfsr[1:0]);
      MODE_AIM: begin
        if (goal_win)
          next_control = (shadow <= COUNTER_MAX - counter_t'(2)) ? UP2 : UP1;
        else
          next_control = (shadow >= counter_t'(2)) ? DN2 : DN1;
      end
      default:     next_control = UP1;
    endcase
  end

endmodule

// File: rtl/ctr_game_driver.sv
// rtl/ctr_game_driver.sv - counter-game player/referee: load, strategy drive, scoreboard, shadow check
module ctr_game_driver
  import ctr_game_pkg::*;
#(
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  input  logic [1:0]         cfg_control,
  input  logic               cfg_goal_win,
  input  counter_t           cfg_initial,
  input  logic [SCORE_W-1:0] cfg_games,
  ctr_game_if.master         game,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] games_won,
  output logic [SCORE_W-1:0] games_lost,
  output logic [SCORE_W-1:0] win_pulses,
  output logic [SCORE_W-1:0] lose_pulses,
  output logic               mismatch
);

  typedef logic [SCORE_W-1:0] score_t;

  function automatic score_t sat_inc(input score_t v);
    return (&v) ? v : v + score_t'(1);
  endfunction

  state_t   state, state_next;
  counter_t shadow, shadow_next;
  control_t control_q, strategy_control;
  score_t   games_played, games_target;
  logic     last_game;
  logic     pulse_error;
  logic     init_c;
  counter_t initial_value_c;

  assign games_target = (cfg_games == '0) ? score_t'(1) : cfg_games;
  // >= rather than == so a mid-session cfg_games reduction still ends the session
  assign last_game    = (sat_inc(games_played) >= games_target);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next      = state;
    init_c          = 1'b0;
    initial_value_c = '0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        init_c          = 1'b1;
        initial_value_c = cfg_initial;
        busy            = 1'b1;
        state_next      = PLAY;
      end
      PLAY: begin
        busy = 1'b1;
        if (game.gameover) state_next = last_game ? DONE : RESYNC;
      end
      RESYNC: begin
        busy       = 1'b1;
        state_next = PLAY;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shadow_next = shadow;
    case (state)
      LOAD:         shadow_next = cfg_initial;
      PLAY, RESYNC: shadow_next = game.gameover ? '0 : apply_control(shadow, control_q);
      default:      shadow_next = shadow;
    endcase
  end

  // Strategy sees the shadow value that will be current when its code is presented.
  ctr_game_strategy #(.LFSR_SEED(LFSR_SEED)) u_strategy (
    .clock         (clock),
    .reset_n       (reset_n),
    .advance       (state_next == PLAY),
    .mode          (mode_t'(cfg_mode)),
    .fixed_control (control_t'(cfg_control)),
    .goal_win      (cfg_goal_win),
    .shadow        (shadow_next),
    .next_control  (strategy_control)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow    <= '0;
      control_q <= UP1;
    end else begin
      shadow    <= shadow_next;
      control_q <= (state_next == PLAY) ? strategy_control : UP1;
    end
  end

  always_comb begin
    pulse_error = 1'b0;
    if (state == PLAY) begin
      if (game.winner && shadow != COUNTER_MAX)   pulse_error = 1'b1;
      if (game.loser && shadow != '0)             pulse_error = 1'b1;
      if (game.winner && game.loser)              pulse_error = 1'b1;
      if (game.gameover && game.who != WHO_WINNER && game.who != WHO_LOSER)
        pulse_error = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      games_won    <= '0;
      games_lost   <= '0;
      win_pulses   <= '0;
      lose_pulses  <= '0;
      games_played <= '0;
      mismatch     <= 1'b0;
    end else if (state == IDLE && start) begin
      games_won    <= '0;
      games_lost   <= '0;
      win_pulses   <= '0;
      lose_pulses  <= '0;
      games_played <= '0;
      mismatch     <= 1'b0;
    end else if (state == PLAY) begin
      if (game.winner) win_pulses  <= sat_inc(win_pulses);
      if (game.loser)  lose_pulses <= sat_inc(lose_pulses);
      if (pulse_error) mismatch    <= 1'b1;
      if (game.gameover) begin
        games_played <= sat_inc(games_played);
        if (game.who == WHO_WINNER)     games_won  <= sat_inc(games_won);
        else if (game.who == WHO_LOSER) games_lost <= sat_inc(games_lost);
      end
    end
  end

  assign game.control       = control_q;
  assign game.init          = init_c;
  assign game.initial_value = initial_value_c;

endmodule

// File: tb/tb_ctr_game_driver.sv
// tb/tb_ctr_game_driver.sv - randomized and directed bench for ctr_game_driver with reference model
module tb_ctr_game_driver;

  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_RESYNC = 3, P_DONE = 4;
  localparam int CMAX = 15;
  localparam int SMAX = 255;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] cfg_control = 2'd0;
  logic       cfg_goal_win = 1'b0;
  logic [3:0] cfg_initial = 4'd0;
  logic [7:0] cfg_games = 8'd1;
  logic       busy, done, mismatch;
  logic [7:0] games_won, games_lost, win_pulses, lose_pulses;

  ctr_game_if gif();

  ctr_game_driver #(.SCORE_W(8), .LFSR_SEED(8'hA5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .cfg_mode(cfg_mode), .cfg_control(cfg_control), .cfg_goal_win(cfg_goal_win),
    .cfg_initial(cfg_initial), .cfg_games(cfg_games), .game(gif),
    .busy(busy), .done(done), .games_won(games_won), .games_lost(games_lost),
    .win_pulses(win_pulses), .lose_pulses(lose_pulses), .mismatch(mismatch)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase, m_shadow, m_control, m_lfsr, m_toggle;
  int m_won, m_lost, m_winp, m_losep, m_played, m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int delta(input int code);
    case (code)
      0:       return 1;
      1:       return 2;
      2:       return -1;
      default: return -2;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic int strategy(input int mode, input int sh);
    case (mode)
      0:       return int'(cfg_control);
      1:       return (m_toggle != 0) ? 3 : 1;
      2:       return m_lfsr % 4;
      default: begin
        if (cfg_goal_win) return (sh <= CMAX - 2) ? 1 : 0;
        return (sh >= 2) ? 3 : 2;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_shadow = 0; m_control = 0; m_lfsr = 'hA5; m_toggle = 0;
    m_won = 0; m_lost = 0; m_winp = 0; m_losep = 0; m_played = 0; m_mis = 0;
  endtask

  // Advance the reference by one clock edge given the inputs presented this cycle.
  task automatic model_edge(input bit s, input bit w, input bit l, input bit g, input int wh);
    int np, ns, target, fb;
    target = (cfg_games == 0) ? 1 : int'(cfg_games);
    np = m_phase;
    ns = m_shadow;
    case (m_phase)
      P_IDLE: if (s) begin
        np = P_LOAD;
        m_won = 0; m_lost = 0; m_winp = 0; m_losep = 0; m_played = 0; m_mis = 0;
      end
      P_LOAD: begin
        np = P_PLAY;
        ns = int'(cfg_initial);
      end
      P_PLAY: begin
        if (w) begin m_winp = sat(m_winp + 1); if (m_shadow != CMAX) m_mis = 1; end
        if (l) begin m_losep = sat(m_losep + 1); if (m_shadow != 0) m_mis = 1; end
        if (w && l) m_mis = 1;
        ns = g ? 0 : (m_shadow + delta(m_control) + 16) % 16;
        if (g) begin
          if (wh == 2) m_won = sat(m_won + 1);
          else if (wh == 1) m_lost = sat(m_lost + 1);
          else m_mis = 1;
          m_played = sat(m_played + 1);
          np = (m_played == target) ? P_DONE : P_RESYNC;
        end
      end
      P_RESYNC: begin
        np = P_PLAY;
        ns = g ? 0 : (m_shadow + delta(m_control) + 16) % 16;
      end
      default: if (!s) np = P_IDLE;
    endcase
    if (np == P_PLAY) begin
      m_control = strategy(int'(cfg_mode), ns);
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
      m_toggle = 1 - m_toggle;
    end else begin
      m_control = 0;
    end
    m_phase = np;
    m_shadow = ns;
  endtask

  task automatic compare_all();
    check("control", gif.control, m_control);
    check("init", gif.init, (m_phase == P_LOAD));
    if (m_phase == P_LOAD) check("initial_value", gif.initial_value, cfg_initial);
    check("busy", busy, (m_phase == P_LOAD || m_phase == P_PLAY || m_phase == P_RESYNC));
    check("done", done, (m_phase == P_DONE));
    check("games_won", games_won, m_won);
    check("games_lost", games_lost, m_lost);
    check("win_pulses", win_pulses, m_winp);
    check("lose_pulses", lose_pulses, m_losep);
    check("mismatch", mismatch, m_mis);
  endtask

  task automatic check_reset();
    check("rst_control", gif.control, 0);
    check("rst_init", gif.init, 0);
    check("rst_initial_value", gif.initial_value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_games_won", games_won, 0);
    check("rst_games_lost", games_lost, 0);
    check("rst_win_pulses", win_pulses, 0);
    check("rst_lose_pulses", lose_pulses, 0);
    check("rst_mismatch", mismatch, 0);
  endtask

  // Called at a falling edge; presents inputs, steps the model, then compares one cycle later.
  task automatic tick(input bit s, input bit w, input bit l, input bit g, input int wh);
    start = s;
    gif.winner = w;
    gif.loser = l;
    gif.gameover = g;
    gif.who = wh[1:0];
    model_edge(s, w, l, g, wh);
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic play_until_shadow(input int target);
    for (int i = 0; i < 20 && m_shadow != target; i++) tick(1, 0, 0, 0, 0);
    check("reach_shadow", m_shadow, target);
  endtask

  task automatic random_session(input int budget);
    int n;
    bit w, l, g;
    cfg_mode     = 2'($urandom_range(0, 3));
    cfg_control  = 2'($urandom_range(0, 3));
    cfg_goal_win = 1'($urandom_range(0, 1));
    cfg_initial  = 4'($urandom_range(0, 15));
    cfg_games    = 8'($urandom_range(0, 3));
    n = 0;
    while (m_phase != P_DONE && n < budget) begin
      w = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 7) == 0);
      g = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) cfg_mode = 2'($urandom_range(0, 3));
      tick(1, w, l, g, int'($urandom_range(0, 3)));
      n++;
    end
    check("sess_done", done, 1);
    tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    gif.winner = 1'b0; gif.loser = 1'b0; gif.gameover = 1'b0; gif.who = 2'b00;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_reset();
    reset_n = 1'b1;
    tick(0, 0, 0, 0, 0);

    // fixed +2 from 3, winner at 15, then WHO=winner
    cfg_mode = 2'd0; cfg_control = 2'd1; cfg_initial = 4'd3; cfg_games = 8'd1;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    play_until_shadow(15);
    tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 1, 2);
    check("fw_win_pulses", win_pulses, 1);
    check("fw_games_won", games_won, 1);
    check("fw_done", done, 1);
    check("fw_mismatch", mismatch, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);

    // aim to zero from 5: codes 11,11,10
    cfg_mode = 2'd3; cfg_goal_win = 1'b0; cfg_initial = 4'd5;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("aim_ctl0", gif.control, 3);
    tick(1, 0, 0, 0, 0);
    check("aim_ctl1", gif.control, 3);
    tick(1, 0, 0, 0, 0);
    check("aim_ctl2", gif.control, 2);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 1);
    check("aim_mismatch", mismatch, 0);
    check("aim_lost", games_lost, 1);
    tick(0, 0, 0, 0, 0);

    // winner while shadow=7 is a disagreement, then async reset mid-PLAY
    cfg_mode = 2'd0; cfg_control = 2'd0; cfg_initial = 4'd0;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    play_until_shadow(7);
    tick(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    check("mm_sticky", mismatch, 1);
    #2 reset_n = 1'b0;
    #1 check_reset();
    model_reset();
    start = 1'b0;
    @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    tick(0, 0, 0, 0, 0);

    // random strategy right after reset walks the LFSR from its seed
    cfg_mode = 2'd2; cfg_initial = 4'd9;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("lfsr_first", gif.control, 1);
    for (int i = 0; i < 16; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 2);
    tick(0, 0, 0, 0, 0);

    // three games, pulses in RESYNC ignored
    cfg_mode = 2'd1; cfg_games = 8'd3; cfg_initial = 4'd0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 2);
    check("mg_resync1", busy, 1);
    tick(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 2);
    check("mg_won", games_won, 2);
    check("mg_lost", games_lost, 1);
    check("mg_pulses", win_pulses + lose_pulses, 0);
    check("mg_done", done, 1);
    tick(0, 0, 0, 0, 0);

    // saturation and restart
    cfg_mode = 2'd0; cfg_control = 2'd0; cfg_initial = 4'd4; cfg_games = 8'd1;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) tick(1, 0, 1, 0, 0);
    check("sat_lose_pulses", lose_pulses, 255);
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("done_hold", done, 1);
    tick(0, 0, 0, 0, 0);
    check("done_cleared", done, 0);
    tick(1, 0, 0, 0, 0);
    check("restart_lose_pulses", lose_pulses, 0);
    check("restart_mismatch", mismatch, 0);

    for (int s = 0; s < 8; s++) random_session(600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctr_game_driver.md
Name: ctr_game_driver

Overview:
- Player/referee on the opposite side of the counter-game block.
- Loads the initial counter value, then drives the 2-bit count-control code every cycle according to a selectable strategy.
- Consumes the game's WINNER/LOSER/GAMEOVER/WHO outputs, keeps a scoreboard, and stops after a programmed number of games.
- Keeps a shadow copy of the game counter and flags any disagreement between the shadow value and the game's pulses.

Parameters:
- COUNTER_SIZE, 4: width of the game counter, shadow counter and initial value.
- SCORE_W, 8: width of every scoreboard counter.
- LFSR_SEED, 8'hA5: value the LFSR takes at reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level request to begin a session.
- cfg_mode  in  2  strategy: 00 fixed, 01 alternate, 10 random, 11 aim.
- cfg_control  in  2  code used in fixed mode.
- cfg_goal_win  in  1  aim mode: 1 steers to all-ones, 0 steers to zero.
- cfg_initial  in  COUNTER_SIZE  value loaded into the game at session start.
- cfg_games  in  SCORE_W  number of games per session; 0 is treated as 1.
- winner  in  1  game WINNER pulse.
- loser  in  1  game LOSER pulse.
- gameover  in  1  game GAMEOVER.
- who  in  2  game WHO: 01 loser, 10 winner.
- control  out  2  count code to the game: 00 +1, 01 +2, 10 -1, 11 -2.
- init  out  1  one-cycle load strobe.
- initial_value  out  COUNTER_SIZE  load value.
- busy  out  1  session in progress.
- done  out  1  session complete.
- games_won  out  SCORE_W  number of games that ended with WHO=10.
- games_lost  out  SCORE_W  number of games that ended with WHO=01.
- win_pulses  out  SCORE_W  number of winner pulses seen.
- lose_pulses  out  SCORE_W  number of loser pulses seen.
- mismatch  out  1  sticky shadow/pulse disagreement flag.

Behaviour:
- Reset (async, while reset_n=0):
  - state=IDLE; control=00, init=0, initial_value=0, busy=0, done=0.
  - All scoreboard counters=0, mismatch=0, shadow=0, LFSR=LFSR_SEED, alt toggle=0, games_played=0.
  - Reset asserted mid-session aborts the session immediately. No output holds its old value.
- FSM states: IDLE, LOAD, PLAY, RESYNC, DONE.
- IDLE:
  - control=00, busy=0.
  - start=1 moves to LOAD and clears scoreboard, mismatch and games_played in the same edge.
- LOAD (exactly 1 cycle):
  - init=1, initial_value=cfg_initial, shadow<=cfg_initial.
  - Then goes to PLAY. busy=1 from LOAD through RESYNC.
- PLAY: control is a registered output computed from the current shadow, LFSR and toggle.
  - fixed: control=cfg_control.
  - alternate: 01 when the toggle is 0, 11 when it is 1; the toggle flips every PLAY cycle, so the sequence is 01,11,01,11...
  - random: control=LFSR[1:0]. LFSR is 8-bit Fibonacci, taps 8,6,5,4, advances every PLAY cycle.
  - aim, goal win, MAX=2^COUNTER_SIZE-1: shadow<=MAX-2 gives 01; otherwise 00.
  - aim, goal lose: shadow>=2 gives 11; otherwise 10.
- Shadow counter:
  - Each cycle in PLAY or RESYNC, shadow<=shadow+delta(control) mod 2^COUNTER_SIZE, using the control value presented that cycle.
  - When gameover=1 is sampled, shadow<=0 instead.
- Pulse counting and checks (PLAY only, suppressed in RESYNC):
  - winner=1: win_pulses++. If shadow!=MAX, set mismatch.
  - loser=1: lose_pulses++. If shadow!=0, set mismatch.
  - winner and loser both 1: both counters increment and mismatch is set.
- gameover=1 sampled in PLAY:
  - who=10: games_won++. who=01: games_lost++. Any other who value: neither counter increments; set mismatch.
  - games_played++.
  - If the new games_played equals max(cfg_games,1), go to DONE; otherwise go to RESYNC.
- RESYNC (1 cycle): control=00, then return to PLAY. Absorbs the game's post-gameover reset and loser pulse.
- DONE:
  - done=1, busy=0, control=00; scoreboard held.
  - start=0 returns to IDLE with done cleared.
  - start still high stays in DONE; no auto-restart.
- Width rules:
  - All scoreboard counters saturate at 2^SCORE_W-1.
  - Shadow arithmetic wraps modulo 2^COUNTER_SIZE.
  - cfg_* inputs are sampled every cycle; changing them mid-session takes effect the next cycle.

Decomposition:
- Package ctr_game_pkg holds:
  - COUNTER_SIZE and the counter_t typedef.
  - Control-code enum: UP1=00, UP2=01, DN1=10, DN2=11.
  - WHO constants: WHO_LOSER=01, WHO_WINNER=10.
  - Strategy-mode enum.
  - FSM state enum.
- One sub-module, ctr_game_strategy: combinational next-control from mode, shadow, LFSR and toggle, plus the LFSR and toggle registers.

Test Plan:
- Reset: assert reset_n=0 mid-PLAY with non-zero scores -> all outputs 0 asynchronously; after release state is IDLE, LFSR=A5.
- Fixed win: mode=00, control=01, cfg_initial=3, cfg_games=1, winner pulse when shadow=15, then gameover/who=10 -> win_pulses=1, games_won=1, done=1, mismatch=0.
- Aim lose: mode=11, goal_win=0, cfg_initial=5 -> control 11,11,10; shadow 3,1,0; loser checked with no mismatch.
- Mismatch: inject winner=1 while shadow=7 in PLAY -> mismatch=1 and stays 1 until the next start.
- Multi-game: cfg_games=3, alternate gameover who=10,01,10 -> games_won=2, games_lost=1; RESYNC each time, pulses during RESYNC not counted; done after the 3rd game.
- Saturation and restart: force 300 loser pulses (SCORE_W=8) -> lose_pulses=255. Drop start in DONE -> IDLE; raise start -> scoreboard cleared.
